// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from fifo_mem and serializes each one as an
// asynchronous-serial frame: start bit, 8 data bits LSB first, optional even
// parity, one stop bit.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   enable     permits starting a new frame (sampled only in IDLE)
//   fifo_empty fifo_mem is_empty
//   fifo_data  fifo_mem data_out, valid the cycle after fifo_read
//   fifo_read  read strobe, one cycle per byte
//   tx         serial line, idle high
//   busy       high from FETCH through STOP
//   byte_done  one-cycle pulse after the stop bit
//   frame_cnt  bytes transmitted since reset (wraps)
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_read,
  output logic        tx,
  output logic        busy,
  output logic        byte_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_d, fifo_read_d, busy_d, byte_done_d;
  logic [15:0]       frame_cnt_d;
  logic              bit_end;

  // Last clock of the current serial bit.
  assign bit_end = (baud_q == BAUD_LAST);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx        <= 1'b1;
      fifo_read <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx        <= tx_d;
      fifo_read <= fifo_read_d;
      busy      <= busy_d;
      byte_done <= byte_done_d;
      frame_cnt <= frame_cnt_d;
    end
  end

  // Next-state and next-output logic; outputs are the values for the next cycle.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tx_d        = tx;
    fifo_read_d = 1'b0;
    byte_done_d = 1'b0;
    frame_cnt_d = frame_cnt;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo_empty) begin
          state_d     = S_FETCH;
          fifo_read_d = 1'b1;
        end
      end

      S_FETCH: begin
        state_d = S_WAIT;
      end

      // fifo_data is valid now; latch it and drive the start bit next cycle.
      S_WAIT: begin
        shift_d  = fifo_data;
        parity_d = ^fifo_data;
        tx_d     = 1'b0;
        baud_d   = '0;
        bit_d    = '0;
        state_d  = S_START;
      end

      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_d      = '0;
          tx_d        = 1'b1;
          byte_done_d = 1'b1;
          frame_cnt_d = frame_cnt + 16'd1;
          state_d     = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (parity off / parity on) share one
// stimulus stream. Each has its own fifo_mem model; a per-cycle monitor
// decodes the serial line against bytes queued when they were written.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic [1:0]  fifo_empty = 2'b11;
  logic [7:0]  fifo_data [2];
  logic [1:0]  fifo_read, tx, busy, byte_done;
  logic [15:0] frame_cnt [2];

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned sent = 0;

  logic [7:0]  exp_q  [2][$];
  logic [7:0]  fq     [2][$];
  int unsigned starts [2][$];

  bit          in_frame [2];
  bit          pend     [2];
  bit          prev_rd  [2];
  int unsigned fcyc     [2];
  int unsigned ferr     [2];
  int unsigned rd_cyc   [2];
  logic [7:0]  cur      [2];
  logic [15:0] exp_cnt  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .fifo_empty(fifo_empty[g]),
      .fifo_data (fifo_data[g]),
      .fifo_read (fifo_read[g]),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .byte_done (byte_done[g]),
      .frame_cnt (frame_cnt[g])
    );
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endfunction

  // Expected line level for frame bit k: start, data LSB first, [even parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int par, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return logic'((b >> (k - 1)) & 8'h01);
    if (k == 9 && par != 0) return logic'($countones(b) % 2);
    return 1'b1;
  endfunction

  // fifo_mem model: registered data_out, registered empty flag.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_read[i]) begin
        chk($sformatf("no_underflow[%0d]", i), 32'(fq[i].size() != 0), 32'(1));
        if (fq[i].size() != 0) fifo_data[i] <= fq[i].pop_front();
      end
      if (wr_en) fq[i].push_back(wr_data);
      fifo_empty[i] <= (fq[i].size() == 0);
    end
  end

  // Monitor: decodes frames and checks byte_done / frame_cnt.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        in_frame[i] = 1'b0;
        pend[i]     = 1'b0;
        prev_rd[i]  = 1'b0;
        exp_cnt[i]  = 16'h0000;
      end else begin
        if (fifo_read[i]) begin
          chk($sformatf("read_one_cycle[%0d]", i), 32'(prev_rd[i]), 32'(0));
          rd_cyc[i] = cyc;
        end
        prev_rd[i] = fifo_read[i];

        if (byte_done[i] || pend[i]) begin
          chk($sformatf("byte_done[%0d]", i), 32'(byte_done[i]), 32'(pend[i]));
          if (pend[i]) chk($sformatf("frame_cnt[%0d]", i), 32'(frame_cnt[i]), 32'(exp_cnt[i]));
          pend[i] = 1'b0;
        end

        if (!in_frame[i]) begin
          if (tx[i] === 1'b0) begin
            in_frame[i] = 1'b1;
            fcyc[i]     = 1;
            ferr[i]     = (busy[i] === 1'b1) ? 0 : 1;
            chk($sformatf("start_latency[%0d]", i), cyc - rd_cyc[i], 32'(2));
            starts[i].push_back(cyc);
            chk($sformatf("frame_expected[%0d]", i), 32'(exp_q[i].size() != 0), 32'(1));
            cur[i] = (exp_q[i].size() != 0) ? exp_q[i].pop_front() : 8'h00;
          end
        end else begin
          if (tx[i] !== exp_bit(cur[i], i, fcyc[i] / CPB)) ferr[i]++;
          if (busy[i] !== 1'b1) ferr[i]++;
          fcyc[i]++;
          if (fcyc[i] == (10 + i) * CPB) begin
            in_frame[i] = 1'b0;
            chk($sformatf("frame_bits[%0d] byte %02h", i, cur[i]), ferr[i], 32'(0));
            exp_cnt[i] = exp_cnt[i] + 16'd1;
            pend[i]    = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_data = b;
    exp_q[0].push_back(b);
    exp_q[1].push_back(b);
    sent++;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Wait until both transmitters are idle with nothing left they may start.
  task automatic wait_quiet(input string name, input int maxc);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < maxc) begin
      @(negedge clk);
      n++;
      if (busy == 2'b00 && !in_frame[0] && !in_frame[1] && (fifo_empty == 2'b11 || !enable))
        stable++;
      else
        stable = 0;
    end
    chk({name, "_quiet"}, 32'(stable >= 3), 32'(1));
  endtask

  task automatic wait_busy(input int maxc);
    int n = 0;
    while (busy[0] !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", 32'(busy[0]), 32'(1));
  endtask

  task automatic chk_cnt(input string name);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_frame_cnt[%0d]", name, i), 32'(frame_cnt[i]), sent);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'(2'b11));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_fifo_read", 32'(fifo_read), 32'(0));
    chk("reset_byte_done", 32'(byte_done), 32'(0));
    chk("reset_frame_cnt0", 32'(frame_cnt[0]), 32'(0));
    chk("reset_frame_cnt1", 32'(frame_cnt[1]), 32'(0));

    // Enabled with an empty FIFO: nothing happens.
    @(posedge clk); #1 enable = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_read !== 2'b00 || tx !== 2'b11 || busy !== 2'b00) bad++;
    end
    chk("empty_idle", bad, 32'(0));

    // Single byte.
    push_byte(8'hA5);
    wait_quiet("single", 200);
    chk_cnt("single");
    chk("single_empty", 32'(fifo_empty), 32'(2'b11));

    // Full FIFO drain, back to back.
    @(posedge clk); #1 enable = 1'b0;
    starts[0].delete();
    starts[1].delete();
    for (int b = 1; b <= 16; b++) push_byte(8'(b));
    @(posedge clk); #1 enable = 1'b1;
    wait_quiet("drain", 2000);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("drain_frames[%0d]", i), starts[i].size(), 32'(16));
      for (int k = 1; k < starts[i].size(); k++)
        chk($sformatf("drain_gap[%0d][%0d]", i, k), starts[i][k] - starts[i][k-1],
            32'((10 + i) * CPB + 3));
    end
    chk_cnt("drain");

    // Parity values for 0x07 (odd ones) and 0x03 (even ones).
    push_byte(8'h07);
    push_byte(8'h03);
    wait_quiet("parity", 400);
    chk_cnt("parity");

    // Enable dropped during data bit 4 of the first of three bytes.
    @(posedge clk); #1 enable = 1'b0;
    push_byte(8'h5A);
    push_byte(8'hC3);
    push_byte(8'h81);
    @(posedge clk); #1 enable = 1'b1;
    wait_busy(20);
    repeat (23) @(posedge clk);
    #1 enable = 1'b0;
    wait_quiet("gate", 200);
    for (int i = 0; i < 2; i++)
      chk($sformatf("gate_remaining[%0d]", i), fq[i].size(), 32'(2));
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (fifo_read !== 2'b00 || busy !== 2'b00) bad++;
    end
    chk("gate_hold", bad, 32'(0));
    @(posedge clk); #1 enable = 1'b1;
    wait_quiet("resume", 400);
    chk("resume_empty", 32'(fifo_empty), 32'(2'b11));
    chk_cnt("resume");

    // Randomized bytes with random gaps and enable toggling.
    for (int n = 0; n < 24; n++) begin
      int guard = 0;
      while ((fq[0].size() > 14 || fq[1].size() > 14) && guard < 2000) begin
        @(posedge clk); #1 enable = 1'b1;
        guard++;
      end
      push_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1 enable = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 enable = 1'b1;
    wait_quiet("random", 3000);
    chk("random_empty", 32'(fifo_empty), 32'(2'b11));
    chk_cnt("random");

    // Reset during data bit 3.
    push_byte(8'h3C);
    wait_busy(20);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sent = 0;
    @(negedge clk);
    chk("midrst_tx", 32'(tx), 32'(2'b11));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_byte_done", 32'(byte_done), 32'(0));
    chk_cnt("midrst");
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (byte_done !== 2'b00 || busy !== 2'b00 || tx !== 2'b11) bad++;
    end
    chk("midrst_quiet", bad, 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
